// File: rtl/ddr_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_rx
//  Purpose  : HDR-DDR receive deserializer. Samples SDA on every SCL edge
//             strobe (rising and falling) and assembles the field selected by
//             the DDR/CCC FSM:
//               PREAMBLE 2 bits, DATA 8 bits, PARITY 2 bits, TOKEN 4 bits,
//               CRC 5 bits.
//             Parity, token and CRC are checked against their expected values.
//             Each data byte goes to the register file and to the CRC engine.
//  Ports    :
//    i_sys_clk / i_sys_rst        clock, asynchronous active-low reset
//    i_ddrccc_rx_en               enable; low clears field state
//    i_ddrccc_rx_mode             field select
//    i_sclgen_scl_pos/neg_edge    1-cycle SCL edge strobes
//    i_sdahnd_rx_sda              synchronized SDA
//    i_crc_crc_value              CRC5 computed over the received bytes
//    o_ddrccc_rx_mode_done        1-cycle pulse, field complete
//    o_ddrccc_preamble            last received preamble {first,second}
//    o_ddrccc_error               1-cycle pulse with done on a check mismatch
//    o_regf_wr_en/o_regf_data_wr  received byte to the register file
//    o_crc_en                     high while in DATA mode
//    o_crc_data_valid/
//    o_crc_parallel_data          received byte to the CRC engine
//  Revision : 1.0  initial release
// ============================================================================
module ddr_rx (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_ddrccc_rx_en,
  input  logic [3:0] i_ddrccc_rx_mode,
  input  logic       i_sclgen_scl_pos_edge,
  input  logic       i_sclgen_scl_neg_edge,
  input  logic       i_sdahnd_rx_sda,
  input  logic [4:0] i_crc_crc_value,
  output logic       o_ddrccc_rx_mode_done,
  output logic [1:0] o_ddrccc_preamble,
  output logic       o_ddrccc_error,
  output logic       o_regf_wr_en,
  output logic [7:0] o_regf_data_wr,
  output logic       o_crc_en,
  output logic       o_crc_data_valid,
  output logic [7:0] o_crc_parallel_data
);

  localparam logic [3:0] MODE_PREAMBLE = 4'b0000;
  localparam logic [3:0] MODE_DATA     = 4'b0111;
  localparam logic [3:0] MODE_PARITY   = 4'b0100;
  localparam logic [3:0] MODE_TOKEN    = 4'b1100;
  localparam logic [3:0] MODE_CRC      = 4'b1101;
  localparam logic [3:0] TOKEN_VALUE   = 4'b1100;

  logic [3:0] mode_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       byte_sel_q, byte_sel_d;
  logic [7:0] d1_q, d1_d;
  logic [7:0] d2_q, d2_d;
  logic [7:0] byte_q, byte_d;
  logic [1:0] preamble_q, preamble_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       wr_q, wr_d;

  logic       w_mode_valid;
  logic [2:0] w_last_idx;
  logic       w_sample;
  logic       w_mode_chg;
  logic [1:0] w_par_exp;
  logic [2:0] w_cnt_base;
  logic [6:0] w_shift_base;
  logic [7:0] w_field;

  // Index of the final bit of the selected field; unknown codes never sample.
  always_comb begin
    w_mode_valid = 1'b1;
    w_last_idx   = 3'd0;
    case (i_ddrccc_rx_mode)
      MODE_PREAMBLE: w_last_idx = 3'd1;
      MODE_DATA:     w_last_idx = 3'd7;
      MODE_PARITY:   w_last_idx = 3'd1;
      MODE_TOKEN:    w_last_idx = 3'd3;
      MODE_CRC:      w_last_idx = 3'd4;
      default:       w_mode_valid = 1'b0;
    endcase
  end

  assign w_sample   = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
  assign w_mode_chg = (i_ddrccc_rx_mode != mode_q) && (bit_cnt_q != 3'd0);

  // Odd bits give P1; even bits give P0 inverted.
  assign w_par_exp = {^{d1_q[7], d1_q[5], d1_q[3], d1_q[1], d2_q[7], d2_q[5], d2_q[3], d2_q[1]},
                      ~^{d1_q[6], d1_q[4], d1_q[2], d1_q[0], d2_q[6], d2_q[4], d2_q[2], d2_q[0]}};

  // A mode switch mid-field drops the partial bits; a strobe in the same
  // cycle then starts the new field.
  assign w_cnt_base   = w_mode_chg ? 3'd0 : bit_cnt_q;
  assign w_shift_base = w_mode_chg ? 7'd0 : shift_q;
  // Shift register is cleared at every field boundary, so the low bits of
  // w_field hold the completed field MSB-first.
  assign w_field      = {w_shift_base, i_sdahnd_rx_sda};

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_sel_d = byte_sel_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    byte_d     = byte_q;
    preamble_d = preamble_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_d       = 1'b0;

    if (!i_ddrccc_rx_en) begin
      bit_cnt_d  = 3'd0;
      shift_d    = 7'd0;
      byte_sel_d = 1'b0;
    end else begin
      bit_cnt_d = w_cnt_base;
      shift_d   = w_shift_base;
      if (w_sample && w_mode_valid) begin
        if (w_cnt_base == w_last_idx) begin
          done_d    = 1'b1;
          bit_cnt_d = 3'd0;
          shift_d   = 7'd0;
          case (i_ddrccc_rx_mode)
            MODE_PREAMBLE: preamble_d = w_field[1:0];
            MODE_DATA: begin
              wr_d       = 1'b1;
              byte_d     = w_field;
              byte_sel_d = ~byte_sel_q;
              if (byte_sel_q) d2_d = w_field;
              else            d1_d = w_field;
            end
            MODE_PARITY: begin
              err_d      = (w_field[1:0] != w_par_exp);
              byte_sel_d = 1'b0;
            end
            MODE_TOKEN: err_d = (w_field[3:0] != TOKEN_VALUE);
            MODE_CRC:   err_d = (w_field[4:0] != i_crc_crc_value);
            default:    err_d = 1'b0;
          endcase
        end else begin
          bit_cnt_d = w_cnt_base + 3'd1;
          shift_d   = w_field[6:0];
        end
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      mode_q     <= MODE_PREAMBLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      byte_sel_q <= 1'b0;
      d1_q       <= 8'd0;
      d2_q       <= 8'd0;
      byte_q     <= 8'd0;
      preamble_q <= 2'b00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      mode_q     <= i_ddrccc_rx_en ? i_ddrccc_rx_mode : MODE_PREAMBLE;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_sel_q <= byte_sel_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      byte_q     <= byte_d;
      preamble_q <= preamble_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_q       <= wr_d;
    end
  end

  assign o_ddrccc_rx_mode_done = done_q;
  assign o_ddrccc_error        = err_q;
  assign o_ddrccc_preamble     = preamble_q;
  assign o_regf_wr_en          = wr_q;
  assign o_regf_data_wr        = byte_q;
  assign o_crc_data_valid      = wr_q;
  assign o_crc_parallel_data   = byte_q;
  // Gated by reset so the enable drops immediately when reset is asserted.
  assign o_crc_en = i_sys_rst && i_ddrccc_rx_en && (i_ddrccc_rx_mode == MODE_DATA);

endmodule
`default_nettype wire

// File: tb/tb_ddr_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_rx
//  Purpose  : Self-checking bench for ddr_rx. Fields are driven bit by bit on
//             random SCL strobes; expected results come from a field-level
//             model of the protocol (stored bytes, parity by bit counting).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddr_rx;

  localparam logic [3:0] M_PRE = 4'b0000;
  localparam logic [3:0] M_DAT = 4'b0111;
  localparam logic [3:0] M_PAR = 4'b0100;
  localparam logic [3:0] M_TOK = 4'b1100;
  localparam logic [3:0] M_CRC = 4'b1101;
  localparam logic [3:0] M_BAD = 4'b1111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic [3:0] rx_mode = M_PRE;
  logic       pos_e = 1'b0;
  logic       neg_e = 1'b0;
  logic       sda = 1'b0;
  logic [4:0] crc_val = 5'd0;
  logic       done, err, wr_en, crc_en, crc_vld;
  logic [1:0] pre;
  logic [7:0] wr_data, crc_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] m_d1 = 8'd0, m_d2 = 8'd0;
  bit         m_sel = 1'b0;
  logic [1:0] m_pre = 2'b00;

  ddr_rx u_dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst_n),
    .i_ddrccc_rx_en        (rx_en),
    .i_ddrccc_rx_mode      (rx_mode),
    .i_sclgen_scl_pos_edge (pos_e),
    .i_sclgen_scl_neg_edge (neg_e),
    .i_sdahnd_rx_sda       (sda),
    .i_crc_crc_value       (crc_val),
    .o_ddrccc_rx_mode_done (done),
    .o_ddrccc_preamble     (pre),
    .o_ddrccc_error        (err),
    .o_regf_wr_en          (wr_en),
    .o_regf_data_wr        (wr_data),
    .o_crc_en              (crc_en),
    .o_crc_data_valid      (crc_vld),
    .o_crc_parallel_data   (crc_data)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present strobes/SDA for one cycle; returns at the following negedge,
  // when anything captured by the posedge is visible.
  task automatic step(input logic p, input logic n, input logic d);
    pos_e = p;
    neg_e = n;
    sda   = d;
    @(negedge clk);
    pos_e = 1'b0;
    neg_e = 1'b0;
  endtask

  task automatic rand_edge(input logic d);
    int pick;
    pick = $urandom_range(2, 0);
    step(pick != 1, pick != 0, d);
  endtask

  function automatic logic [1:0] model_parity();
    int odd_ones, even_ones;
    odd_ones = 0;
    even_ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) odd_ones += m_d1[i] + m_d2[i];
      else            even_ones += m_d1[i] + m_d2[i];
    end
    return {logic'(odd_ones % 2 == 1), logic'(even_ones % 2 == 0)};
  endfunction

  function automatic int field_len(input logic [3:0] m);
    case (m)
      M_PRE:   return 2;
      M_DAT:   return 8;
      M_PAR:   return 2;
      M_TOK:   return 4;
      default: return 5;
    endcase
  endfunction

  // Send one complete field MSB-first with random idle gaps, then compare the
  // completion cycle against the model.
  task automatic send_field(input logic [3:0] m, input logic [7:0] v, input int max_gap);
    int len, gap;
    logic exp_err, is_dat;
    len = field_len(m);
    rx_mode = m;
    for (int i = len - 1; i >= 0; i--) begin
      gap = $urandom_range(max_gap, 0);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'b0, 1'($urandom_range(1, 0)));
        check("idle_done", done, 1'b0);
      end
      rand_edge(v[i]);
      if (i > 0) check("early_done", done, 1'b0);
    end
    exp_err = 1'b0;
    is_dat  = (m == M_DAT);
    case (m)
      M_PRE: m_pre = v[1:0];
      M_DAT: begin
        if (m_sel) m_d2 = v;
        else       m_d1 = v;
        m_sel = ~m_sel;
      end
      M_PAR: begin
        exp_err = (v[1:0] != model_parity());
        m_sel = 1'b0;
      end
      M_TOK:   exp_err = (v[3:0] != 4'b1100);
      default: exp_err = (v[4:0] != crc_val);
    endcase
    check("done", done, 1'b1);
    check("error", err, exp_err);
    check("wr_en", wr_en, is_dat);
    check("crc_valid", crc_vld, is_dat);
    check("crc_en", crc_en, is_dat);
    if (is_dat) begin
      check("wr_data", wr_data, v);
      check("crc_data", crc_data, v);
    end
    check("preamble", pre, m_pre);
  endtask

  task automatic send_partial(input logic [3:0] m, input int nbits);
    rx_mode = m;
    for (int i = 0; i < nbits; i++) begin
      rand_edge(1'($urandom_range(1, 0)));
      check("partial_done", done, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] v;
    int r;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_wr", wr_en, 1'b0);
    check("rst_pre", pre, 2'b00);
    check("rst_data", wr_data, 8'h00);
    check("rst_crc_en", crc_en, 1'b0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    @(negedge clk);

    // Directed protocol sequence
    send_field(M_PRE, 8'b01, 1);
    check("pre_01", pre, 2'b01);
    send_field(M_DAT, 8'hA5, 1);
    send_field(M_DAT, 8'h3C, 0);
    send_field(M_PAR, 8'b01, 1);
    check("par_ok_err", err, 1'b0);
    send_field(M_PAR, 8'b11, 1);
    check("par_bad_err", err, 1'b1);
    send_field(M_TOK, 8'b1100, 1);
    send_field(M_TOK, 8'b1101, 0);
    crc_val = 5'h13;
    send_field(M_CRC, 8'b10011, 1);
    send_field(M_CRC, 8'b10010, 0);

    // Unknown mode: edges ignored
    send_partial(M_BAD, 6);

    // Mode change mid-field discards the partial byte
    send_partial(M_DAT, 5);
    rx_mode = M_PRE;
    step(1'b0, 1'b0, 1'b0);
    check("chg_done", done, 1'b0);
    check("chg_wr", wr_en, 1'b0);
    send_field(M_PRE, 8'b10, 0);

    // Async reset mid-DATA
    send_partial(M_DAT, 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pre", pre, 2'b00);
    check("arst_data", wr_data, 8'h00);
    check("arst_crc_en", crc_en, 1'b0);
    check("arst_done", done, 1'b0);
    m_d1 = 8'd0; m_d2 = 8'd0; m_sel = 1'b0; m_pre = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    send_field(M_DAT, 8'h5E, 1);

    // Randomized field sequences
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(9, 0);
      if (r == 0) begin
        rx_en = 1'b0;
        repeat (2) begin
          rand_edge(1'b1);
          check("dis_done", done, 1'b0);
          check("dis_crc_en", crc_en, 1'b0);
        end
        rx_en = 1'b1;
        m_sel = 1'b0;
      end else if (r == 1) begin
        send_partial(M_DAT, $urandom_range(7, 1));
        rx_mode = M_BAD;
        step(1'b0, 1'b0, 1'b0);
        check("abort_done", done, 1'b0);
      end
      v = 8'($urandom);
      case ($urandom_range(4, 0))
        0: send_field(M_PRE, v, 2);
        1: send_field(M_DAT, v, 2);
        2: send_field(M_PAR, ($urandom_range(1, 0) == 1) ? {6'd0, model_parity()} : v, 2);
        3: send_field(M_TOK, ($urandom_range(1, 0) == 1) ? 8'h0C : v, 2);
        default: begin
          crc_val = 5'($urandom);
          send_field(M_CRC, ($urandom_range(1, 0) == 1) ? {3'd0, crc_val} : v, 2);
        end
      endcase
    end

    step(1'b0, 1'b0, 1'b0);
    check("final_done", done, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
